// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_adc_ctrl
// Purpose  : Successive-approximation conversion controller for the
//            real-number-modelled ADC/DAC datapath. It samples a real-valued
//            input once per conversion. It then resolves one bit per cycle,
//            MSB first, by comparing the held sample against an internal
//            behavioural DAC driven by the trial code.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   BITS      resolution in bits, legal range 2..16
//   VREF      full-scale reference (real); LSB = VREF / 2^BITS
// Ports
//   clk       in   1     sole clock, rising edge
//   rst       in   1     asynchronous, active-low reset
//   start     in   1     conversion request, honoured in IDLE or DONE
//   abort     in   1     cancel the conversion in progress (SAMPLE/CONV)
//   vin       in   real  analog input, captured at the SAMPLE exit edge
//   busy      out  1     high in SAMPLE and CONV
//   done      out  1     one-cycle pulse in DONE
//   dout      out  BITS  last completed result, held between conversions
//   dac_code  out  BITS  trial code currently driven to the DAC
//   dac_v     out  real  DAC output voltage, dac_code * LSB
// ============================================================================
module sar_adc_ctrl #(
    parameter int  BITS = 8,
    parameter real VREF = 1.0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  real             vin,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] dout,
    output logic [BITS-1:0] dac_code,
    output real             dac_v
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Bit-index counter width: enough to hold BITS-1, never narrower than 1.
    localparam int KW = (BITS > 2) ? $clog2(BITS) : 1;

    // BITS <= 16 keeps every code * LSB product exactly representable, so the
    // comparator below sees exact DAC levels.
    localparam real LSB = VREF / real'(32'd1 << BITS);

    localparam logic [BITS-1:0] MSB_CODE = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [KW-1:0]   K_TOP    = KW'(BITS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_CONV   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]      state_q, state_d;
    real             held_q,  held_d;    // clamped input sample
    logic [BITS-1:0] code_q,  code_d;    // trial code driven to the DAC
    logic [KW-1:0]   k_q,     k_d;       // bit currently being resolved
    logic [BITS-1:0] dout_q,  dout_d;    // last completed result

    // ------------------------------------------------------------------------
    // Behavioural DAC, input clamp and comparator
    // ------------------------------------------------------------------------
    real  trial_v;
    real  vin_clamped;
    logic ge;

    always_comb begin
        trial_v = real'(code_q) * LSB;
    end

    // Out-of-range inputs saturate to the rails. This keeps the held sample
    // within [0, VREF], which the result guarantee depends on.
    always_comb begin
        if (vin < 0.0) begin
            vin_clamped = 0.0;
        end else if (vin > VREF) begin
            vin_clamped = VREF;
        end else begin
            vin_clamped = vin;
        end
    end

    always_comb begin
        ge = (held_q >= trial_v);
    end

    // ------------------------------------------------------------------------
    // Process 1: state and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            held_q  <= 0.0;
            code_q  <= '0;
            k_q     <= K_TOP;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            code_q  <= code_d;
            k_q     <= k_d;
            dout_q  <= dout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                state_d = abort ? ST_IDLE : ST_CONV;
            end
            ST_CONV: begin
                // abort wins over completing the final bit on the same edge
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (k_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // back-to-back conversions skip IDLE entirely
                state_d = start ? ST_SAMPLE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------------
    always_comb begin
        held_d = held_q;
        code_d = code_q;
        k_d    = k_q;
        dout_d = dout_q;
        case (state_q)
            ST_IDLE: begin
                code_d = '0;
                k_d    = K_TOP;
            end
            ST_SAMPLE: begin
                if (abort) begin
                    code_d = '0;
                    k_d    = K_TOP;
                end else begin
                    held_d = vin_clamped;
                    code_d = MSB_CODE;
                    k_d    = K_TOP;
                end
            end
            ST_CONV: begin
                if (abort) begin
                    // dout is left untouched so the previous result survives
                    code_d = '0;
                    k_d    = K_TOP;
                end else begin
                    // The trial bit stays only if the DAC did not overshoot.
                    if (!ge) begin
                        code_d[k_q] = 1'b0;
                    end
                    if (k_q != '0) begin
                        code_d[k_q - KW'(1)] = 1'b1;
                        k_d                  = k_q - KW'(1);
                    end else begin
                        dout_d = code_d;
                    end
                end
            end
            ST_DONE: begin
                // Clearing here means the DAC idles at 0 V whether the next
                // state is IDLE or a fresh SAMPLE.
                code_d = '0;
                k_d    = K_TOP;
            end
            default: begin
                code_d = '0;
                k_d    = K_TOP;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        busy     = (state_q == ST_SAMPLE) || (state_q == ST_CONV);
        done     = (state_q == ST_DONE);
        dout     = dout_q;
        dac_code = code_q;
        dac_v    = trial_v;
    end

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_adc_ctrl
// Purpose  : Self-checking bench for sar_adc_ctrl (BITS=8, VREF=1.0).
//            A timeline model tracks the number of cycles since the start
//            request was accepted and computes each result directly as
//            floor(clamp(vin)/LSB). One compare process checks every output
//            on every falling edge and right after an asynchronous reset.
//            Directed conversions also carry hand-computed literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_adc_ctrl;

    localparam int  BITS   = 8;
    localparam real VREF   = 1.0;
    localparam real LSB    = VREF / 256.0;
    localparam int  FULL   = (1 << BITS) - 1;
    localparam int  P_DONE = BITS + 2;

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    real             vin   = 0.0;
    logic            busy;
    logic            done;
    logic [BITS-1:0] dout;
    logic [BITS-1:0] dac_code;
    real             dac_v;

    sar_adc_ctrl #(
        .BITS (BITS),
        .VREF (VREF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .vin      (vin),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .dac_code (dac_code),
        .dac_v    (dac_v)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model
    // pos: 0 idle, 1 sampling, 2..BITS+1 resolving bit (pos-2 from MSB),
    //      BITS+2 done pulse.
    // ------------------------------------------------------------------------
    int total  = 0;
    int bad    = 0;
    int pos    = 0;
    int m_res  = 0;
    int m_dout = 0;
    int cyc    = 0;

    int lit_tok    = 0;
    int lit_chk    = 0;
    int lit_exp    = 0;
    int lit_accept = 0;

    function automatic int sar_result(input real v);
        real h;
        h = (v < 0.0) ? 0.0 : ((v > VREF) ? VREF : v);
        if (h >= VREF) return FULL;
        return int'($floor(h / LSB));
    endfunction

    // Trial code at resolution step i: resolved upper bits plus trial bit.
    function automatic int trial_code(input int r, input int i);
        int hi_mask;
        hi_mask = ~((1 << (BITS - i)) - 1);
        return (r & hi_mask) | (1 << (BITS - 1 - i));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos    <= 0;
            m_dout <= 0;
        end else begin
            cyc <= cyc + 1;
            if (pos == 0) begin
                if (start) pos <= 1;
            end else if (pos == P_DONE) begin
                pos <= start ? 1 : 0;
            end else if (abort) begin
                pos <= 0;
            end else if (pos == 1) begin
                m_res <= sar_result(vin);
                pos   <= 2;
            end else if (pos == BITS + 1) begin
                m_dout <= m_res;
                pos    <= P_DONE;
            end else begin
                pos <= pos + 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------------
    task automatic check(input string name, input int got, input int exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_real(input string name, input real got, input real exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %f expected %f (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always begin : compare
        int exp_code;
        @(negedge clk or negedge rst);
        #1;
        check("busy", int'(busy), (pos >= 1 && pos <= BITS + 1) ? 1 : 0);
        check("done", int'(done), (pos == P_DONE) ? 1 : 0);
        check("dout", int'(dout), m_dout);
        if (pos == 0 || (pos >= 2 && pos <= BITS + 1)) begin
            exp_code = (pos == 0) ? 0 : trial_code(m_res, pos - 2);
            check("dac_code", int'(dac_code), exp_code);
            check_real("dac_v", dac_v, real'(exp_code) * LSB);
        end
        if (done === 1'b1 && lit_chk != lit_tok) begin
            check("literal_dout", int'(dout), lit_exp);
            check("literal_latency", cyc - lit_accept, BITS + 1);
            lit_chk = lit_tok;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic conv_lit(input real v, input int exp);
        vin        = v;
        start      = 1'b1;
        lit_exp    = exp;
        lit_accept = cyc + 1;
        lit_tok    = lit_tok + 1;
        tick();
        start = 1'b0;
        repeat (BITS + 4) tick();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        tick();

        // hand-computed rail, midscale and clamp results
        conv_lit(0.5, 8'h80);
        conv_lit(0.0, 8'h00);
        conv_lit(1.0, 8'hFF);
        conv_lit(-0.3, 8'h00);
        conv_lit(1.7, 8'hFF);

        // interior value; vin moves during CONV and must not matter
        vin        = 0.30;
        start      = 1'b1;
        lit_exp    = 76;
        lit_accept = cyc + 1;
        lit_tok    = lit_tok + 1;
        tick();
        start = 1'b0;
        tick();
        vin = 0.9;
        repeat (BITS + 4) tick();

        // abort during the third resolution cycle; dout must stay 76
        vin   = 0.5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (4) tick();

        // start held high: back-to-back conversions
        vin   = 0.25;
        start = 1'b1;
        repeat (BITS + 2) tick();
        vin = 0.75;
        repeat (BITS + 2) tick();
        start = 1'b0;
        repeat (BITS + 4) tick();

        // start pulsed while busy is ignored
        vin   = 0.6;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (BITS + 4) tick();

        // reset dropped between clock edges mid-conversion
        vin   = 0.4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #1;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (BITS + 3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (BITS + 4) tick();

        // randomized traffic
        repeat (3000) begin
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) begin
                vin = real'($urandom_range(0, 1400)) / 1000.0 - 0.2;
            end
            if ($urandom_range(0, 799) == 0) begin
                #1;
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            tick();
        end

        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
